// File: rtl/sobel_edge_filter.sv
// 3x3 Sobel gradient-magnitude stage for a raster-order greyscale stream.
// Two line buffers feed a sliding window; results come out two clocks after the triggering pixel.
module sobel_edge_filter #(
    parameter int DATA_W = 12,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iDVAL,
    input  logic              iSOF,
    input  logic [DATA_W-1:0] iDATA,
    input  logic              iMODE,
    output logic              oDVAL,
    output logic [DATA_W-1:0] oDATA,
    output logic [10:0]       oX,
    output logic [10:0]       oY,
    output logic              oEOF
);

    localparam int          AW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int          GW       = DATA_W + 3;
    localparam logic [10:0] COL_LAST = 11'(IMG_W - 1);
    localparam logic [10:0] ROW_LAST = 11'(IMG_H - 1);
    localparam logic [GW-1:0] SAT_MAX = {3'b000, {DATA_W{1'b1}}};

    // Weighted 1-2-1 column/row sum, always non-negative and below 2^(GW-1).
    function automatic logic [GW-1:0] weigh(input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b,
                                            input logic [DATA_W-1:0] c);
        return {3'b000, a} + {2'b00, b, 1'b0} + {3'b000, c};
    endfunction

    function automatic logic [DATA_W-1:0] sat_mag(input logic signed [GW-1:0] g);
        logic [GW-1:0] mag;
        if (g[GW-1]) begin
            mag = -g;
        end else begin
            mag = g;
        end
        if (mag > SAT_MAX) begin
            return {DATA_W{1'b1}};
        end else begin
            return mag[DATA_W-1:0];
        end
    endfunction

    logic [10:0]       col_r, row_r, col_s, row_s;
    logic [AW-1:0]     addr_s;
    logic              accept_s, origin_s, emit_s, mode_r;
    logic [DATA_W-1:0] line1_r [IMG_W];
    logic [DATA_W-1:0] line2_r [IMG_W];
    logic [DATA_W-1:0] tap1_s, tap2_s;
    logic [DATA_W-1:0] win_r [3][3];

    logic              s1_valid_r, s1_eof_r;
    logic [10:0]       s1_x_r, s1_y_r;
    logic              s2_valid_r, s2_eof_r;
    logic [10:0]       s2_x_r, s2_y_r;
    logic [DATA_W-1:0] s2_data_r;

    logic signed [GW-1:0] gx_s, gy_s;
    logic [DATA_W-1:0]    mag_s;

    // Effective coordinates of the incoming pixel; iSOF forces a resync to (0,0).
    always_comb begin
        accept_s = iDVAL;
        if (iSOF) begin
            col_s = 11'd0;
            row_s = 11'd0;
        end else begin
            col_s = col_r;
            row_s = row_r;
        end
        addr_s   = col_s[AW-1:0];
        tap1_s   = line1_r[addr_s];
        tap2_s   = line2_r[addr_s];
        origin_s = (col_s == 11'd0) && (row_s == 11'd0);
        emit_s   = accept_s && (col_s >= 11'd2) && (row_s >= 11'd2);
    end

    // Raster position counters, advanced only by accepted pixels.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_r <= 11'd0;
            row_r <= 11'd0;
        end else if (accept_s) begin
            if (col_s == COL_LAST) begin
                col_r <= 11'd0;
                row_r <= (row_s == ROW_LAST) ? 11'd0 : row_s + 11'd1;
            end else begin
                col_r <= col_s + 11'd1;
                row_r <= row_s;
            end
        end
    end

    // Frame mode is latched only with the first pixel of a frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_r <= 1'b0;
        end else if (accept_s && origin_s) begin
            mode_r <= iMODE;
        end
    end

    // Line buffers (not reset): read-before-write shifts the column down one row.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            line2_r[addr_s] <= tap1_s;
            line1_r[addr_s] <= iDATA;
        end
    end

    // 3x3 window shifts left; the new right column is taken straight from the buffers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_r[r][c] <= {DATA_W{1'b0}};
                end
            end
        end else if (accept_s) begin
            for (int r = 0; r < 3; r++) begin
                win_r[r][0] <= win_r[r][1];
                win_r[r][1] <= win_r[r][2];
            end
            win_r[0][2] <= tap2_s;
            win_r[1][2] <= tap1_s;
            win_r[2][2] <= iDATA;
        end
    end

    // Stage 1 tags the window just loaded with its centre coordinates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_r <= 1'b0;
            s1_eof_r   <= 1'b0;
            s1_x_r     <= 11'd0;
            s1_y_r     <= 11'd0;
        end else begin
            s1_valid_r <= emit_s;
            s1_eof_r   <= emit_s && (col_s == COL_LAST) && (row_s == ROW_LAST);
            s1_x_r     <= col_s - 11'd1;
            s1_y_r     <= row_s - 11'd1;
        end
    end

    // Kernel arithmetic on the stage-1 window.
    always_comb begin
        gx_s = $signed(weigh(win_r[0][2], win_r[1][2], win_r[2][2]))
             - $signed(weigh(win_r[0][0], win_r[1][0], win_r[2][0]));
        gy_s = $signed(weigh(win_r[2][0], win_r[2][1], win_r[2][2]))
             - $signed(weigh(win_r[0][0], win_r[0][1], win_r[0][2]));
        if (mode_r) begin
            mag_s = sat_mag(gy_s);
        end else begin
            mag_s = sat_mag(gx_s);
        end
    end

    // Stage 2 holds the saturated magnitude.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid_r <= 1'b0;
            s2_eof_r   <= 1'b0;
            s2_x_r     <= 11'd0;
            s2_y_r     <= 11'd0;
            s2_data_r  <= {DATA_W{1'b0}};
        end else begin
            s2_valid_r <= s1_valid_r;
            s2_eof_r   <= s1_eof_r;
            s2_x_r     <= s1_x_r;
            s2_y_r     <= s1_y_r;
            s2_data_r  <= mag_s;
        end
    end

    // Output register: data and coordinates hold between results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            oDVAL <= 1'b0;
            oEOF  <= 1'b0;
            oDATA <= {DATA_W{1'b0}};
            oX    <= 11'd0;
            oY    <= 11'd0;
        end else begin
            oDVAL <= s2_valid_r;
            oEOF  <= s2_valid_r && s2_eof_r;
            if (s2_valid_r) begin
                oDATA <= s2_data_r;
                oX    <= s2_x_r;
                oY    <= s2_y_r;
            end
        end
    end

endmodule

// File: tb/tb_sobel_edge_filter.sv
// Randomised bench for sobel_edge_filter on a 6x4 image, checked against a whole-frame
// arithmetic model of the Sobel magnitude including result timing.
module tb_sobel_edge_filter;
    localparam int W = 6;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst, iDVAL, iSOF, iMODE;
    logic [11:0] iDATA;
    logic        oDVAL, oEOF;
    logic [11:0] oDATA;
    logic [10:0] oX, oY;

    sobel_edge_filter #(.DATA_W(12), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .iDVAL(iDVAL), .iSOF(iSOF), .iDATA(iDATA), .iMODE(iMODE),
        .oDVAL(oDVAL), .oDATA(oDATA), .oX(oX), .oY(oY), .oEOF(oEOF)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] d;
        logic [10:0] x;
        logic [10:0] y;
        logic        e;
        int          t;
    } res_t;

    res_t obs[$];
    res_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   img[H][W];
    int   acc[H][W];

    // cyc names the posedge just passed when read at a negedge, the next one after it
    always @(negedge clk) begin
        res_t r;
        cyc <= cyc + 1;
        if (oDVAL === 1'b1) begin
            r.d = oDATA; r.x = oX; r.y = oY; r.e = oEOF; r.t = cyc;
            obs.push_back(r);
        end
    end

    function automatic string fmt(input res_t r);
        return $sformatf("d=%0d x=%0d y=%0d eof=%0d t=%0d", r.d, r.x, r.y, r.e, r.t);
    endfunction

    // Reference: Sobel over every interior pixel of img, due 2 clks after pixel (x+1,y+1).
    function automatic void build_exp(input logic mode);
        for (int y = 1; y < H - 1; y++) begin
            for (int x = 1; x < W - 1; x++) begin
                int   gx, gy, g;
                res_t r;
                gx = (img[y-1][x+1] + 2 * img[y][x+1] + img[y+1][x+1])
                   - (img[y-1][x-1] + 2 * img[y][x-1] + img[y+1][x-1]);
                gy = (img[y+1][x-1] + 2 * img[y+1][x] + img[y+1][x+1])
                   - (img[y-1][x-1] + 2 * img[y-1][x] + img[y-1][x+1]);
                g = mode ? gy : gx;
                if (g < 0) g = -g;
                if (g > 4095) g = 4095;
                r.d = 12'(g); r.x = 11'(x); r.y = 11'(y);
                r.e = (x == W - 2) && (y == H - 2);
                r.t = acc[y+1][x+1] + 2;
                exp_q.push_back(r);
            end
        end
    endfunction

    function automatic void fill_step(input int lo, input int hi);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = (x < 3) ? lo : hi;
    endfunction

    function automatic void fill_rand();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = int'($urandom_range(4095));
    endfunction

    task automatic drive_frame(input int gap_pct, input logic mode, input int toggle_at,
                               input int npix, input bit sof);
        for (int i = 0; i < npix; i++) begin
            while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                @(negedge clk); #1;
                iDVAL = 1'b0; iSOF = 1'($urandom_range(1)); iDATA = 12'($urandom);
            end
            @(negedge clk); #1;
            iDVAL = 1'b1;
            iSOF  = sof && (i == 0);
            iDATA = 12'(img[i / W][i % W]);
            iMODE = (i < toggle_at) ? mode : ~mode;
            acc[i / W][i % W] = cyc;
        end
        @(negedge clk); #1;
        iDVAL = 1'b0; iSOF = 1'b0;
    endtask

    task automatic drain();
        repeat (4) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; iDVAL = 1'b0; iSOF = 1'b0; iMODE = 1'b0; iDATA = 12'd0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({oDVAL, oDATA, oX, oY, oEOF} !== 36'd0)
            $display("FAIL reset: got dval=%0b d=%0d x=%0d y=%0d eof=%0b, expected all 0",
                     oDVAL, oDATA, oX, oY, oEOF);
        else n_pass++;
        rst = 1'b1;
    endtask

    task automatic test_flat();
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 100;
        obs.delete(); exp_q.delete();
        drive_frame(0, 1'b0, W * H, W * H, 1'b1);
        drain();
        build_exp(1'b0);
        n_checks++;
        if (obs.size() != 8) $display("FAIL flat_count: got %0d results, expected 8", obs.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            n_checks++;
            if (obs[i] !== exp_q[i]) $display("FAIL flat[%0d]: got %s, expected %s", i, fmt(obs[i]), fmt(exp_q[i]));
            else n_pass++;
        end
    endtask

    task automatic test_step();
        int hits;
        for (int m = 0; m < 2; m++) begin
            fill_step(0, 1000);
            obs.delete(); exp_q.delete();
            drive_frame(0, 1'(m), W * H, W * H, 1'b1);
            drain();
            build_exp(1'(m));
            hits = 0;
            foreach (obs[i]) if (obs[i].d == 12'd4000) hits++;
            n_checks++;
            if (hits != ((m == 0) ? 4 : 0)) $display("FAIL step_4000_count mode=%0d: got %0d, expected %0d", m, hits, (m == 0) ? 4 : 0);
            else n_pass++;
            n_checks++;
            if (obs.size() != exp_q.size()) $display("FAIL step_count mode=%0d: got %0d, expected %0d", m, obs.size(), exp_q.size());
            else n_pass++;
            for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
                n_checks++;
                if (obs[i] !== exp_q[i]) $display("FAIL step[%0d] mode=%0d: got %s, expected %s", i, m, fmt(obs[i]), fmt(exp_q[i]));
                else n_pass++;
            end
        end
    endtask

    task automatic test_saturation_gaps();
        for (int g = 0; g < 2; g++) begin
            fill_step(0, 4095);
            obs.delete(); exp_q.delete();
            drive_frame((g == 0) ? 0 : 50, 1'b0, W * H, W * H, 1'b1);
            drain();
            build_exp(1'b0);
            n_checks++;
            if (obs.size() != exp_q.size()) $display("FAIL sat_count gaps=%0d: got %0d, expected %0d", g, obs.size(), exp_q.size());
            else n_pass++;
            for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
                n_checks++;
                if (obs[i] !== exp_q[i]) $display("FAIL sat[%0d] gaps=%0d: got %s, expected %s", i, g, fmt(obs[i]), fmt(exp_q[i]));
                else n_pass++;
            end
        end
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 4; f++) begin
            logic m;
            m = 1'($urandom_range(1));
            fill_rand();
            obs.delete(); exp_q.delete();
            drive_frame(25, m, W * H, W * H, 1'b1);
            drain();
            build_exp(m);
            n_checks++;
            if (obs.size() != exp_q.size()) $display("FAIL rand_count f=%0d: got %0d, expected %0d", f, obs.size(), exp_q.size());
            else n_pass++;
            for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
                n_checks++;
                if (obs[i] !== exp_q[i]) $display("FAIL rand[%0d] f=%0d: got %s, expected %s", i, f, fmt(obs[i]), fmt(exp_q[i]));
                else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        obs.delete(); exp_q.delete();
        fill_rand();
        drive_frame(0, 1'b0, W * H, W * H, 1'b1);
        build_exp(1'b0);
        fill_rand();
        drive_frame(0, 1'b1, W * H, W * H, 1'b0);
        build_exp(1'b1);
        drain();
        n_checks++;
        if (obs.size() != exp_q.size()) $display("FAIL b2b_count: got %0d, expected %0d", obs.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            n_checks++;
            if (obs[i] !== exp_q[i]) $display("FAIL b2b[%0d]: got %s, expected %s", i, fmt(obs[i]), fmt(exp_q[i]));
            else n_pass++;
        end
    endtask

    task automatic test_sof_resync();
        obs.delete(); exp_q.delete();
        fill_rand();
        drive_frame(0, 1'b0, W * H, 9, 1'b1);
        fill_rand();
        drive_frame(0, 1'b1, W * H, W * H, 1'b1);
        drain();
        build_exp(1'b1);
        n_checks++;
        if (obs.size() != 8) $display("FAIL sof_count: got %0d, expected 8", obs.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            n_checks++;
            if (obs[i] !== exp_q[i]) $display("FAIL sof[%0d]: got %s, expected %s", i, fmt(obs[i]), fmt(exp_q[i]));
            else n_pass++;
        end
    endtask

    task automatic test_mode_toggle();
        obs.delete(); exp_q.delete();
        fill_rand();
        drive_frame(0, 1'b1, 10, W * H, 1'b1);
        build_exp(1'b1);
        fill_rand();
        drive_frame(0, 1'b0, 7, W * H, 1'b1);
        build_exp(1'b0);
        drain();
        n_checks++;
        if (obs.size() != exp_q.size()) $display("FAIL mode_count: got %0d, expected %0d", obs.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            n_checks++;
            if (obs[i] !== exp_q[i]) $display("FAIL mode[%0d]: got %s, expected %s", i, fmt(obs[i]), fmt(exp_q[i]));
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        fill_rand();
        drive_frame(0, 1'b0, W * H, 15, 1'b1);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({oDVAL, oDATA, oX, oY, oEOF} !== 36'd0)
            $display("FAIL reset_mid: got dval=%0b d=%0d x=%0d y=%0d eof=%0b, expected all 0",
                     oDVAL, oDATA, oX, oY, oEOF);
        else n_pass++;
        @(negedge clk); #1;
        rst = 1'b1;
        obs.delete(); exp_q.delete();
        fill_rand();
        drive_frame(20, 1'b1, W * H, W * H, 1'b0);
        drain();
        build_exp(1'b1);
        n_checks++;
        if (obs.size() != exp_q.size()) $display("FAIL rstmid_count: got %0d, expected %0d", obs.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            n_checks++;
            if (obs[i] !== exp_q[i]) $display("FAIL rstmid[%0d]: got %s, expected %s", i, fmt(obs[i]), fmt(exp_q[i]));
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_flat();
        test_step();
        test_saturation_gaps();
        test_random_frames();
        test_back_to_back();
        test_sof_resync();
        test_mode_toggle();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
